// File: rtl/memory_responder.sv
// Slave end of the MAR/MDR memory bus: captures a Read/Write strobe, waits
// WAIT_STATES cycles, accesses an internal word RAM and answers via MemReady.
module memory_responder #(
  parameter int BITS        = 32,
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Read,
  input  logic            Write,
  input  logic [BITS-1:0] MARVal,
  input  logic [BITS-1:0] MDRVal,
  output logic [BITS-1:0] MDataIn,
  output logic            MemReady,
  output logic            MemBusy,
  output logic            MemErr
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [BITS-1:0]        addr_q, addr_d;
  logic [BITS-1:0]        data_q, data_d;
  logic                   wr_q, wr_d;
  logic [BITS-1:0]        rdata_q, rdata_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic [BITS-1:0]        mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0]   idx;
  logic                   oor, do_acc, ram_we;

  assign idx    = addr_q[ADDR_BITS-1:0];
  assign oor    = addr_q[BITS-1:ADDR_BITS] != '0;
  assign do_acc = (state_q == ACCESS) && (cnt_q == 4'd0);
  // state_q is reset asynchronously, so a reset mid-ACCESS kills the write
  assign ram_we = do_acc && wr_q && !oor;

  always_ff @(posedge clk) begin
    if (ram_we) mem[idx] <= data_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (Read ^ Write) begin
          state_d = ACCESS;
          cnt_d   = WS;
          addr_d  = MARVal;
          data_d  = MDRVal;
          wr_d    = Write;
          busy_d  = 1'b1;
        end else if (Read && Write) begin
          state_d = DONE;
          ready_d = 1'b1;
          err_d   = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          err_d   = oor;
          if (!wr_q) rdata_d = oor ? '0 : mem[idx];
        end
      end
      DONE: begin
        if (!(Read || Write)) begin
          state_d = IDLE;
          ready_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign MDataIn  = rdata_q;
  assign MemReady = ready_q;
  assign MemBusy  = busy_q;
  assign MemErr   = err_q;

endmodule
